// File: rtl/pheap_arb_pkg.sv
// Shared types for the pheap arbiter: pheap opcodes and arbiter FSM states.
package pheapTypes;

  typedef enum logic {
    LEQ = 1'b0,
    DEQ = 1'b1
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DEQ_WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/pheap_arb_rr.sv
// Round-robin request selector: first asserted request at or after rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic            any
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = PW'((32'(rr_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/pheap_arb.sv
// Arbitrates NREQ requesters onto one pheap command port with a single
// operation in flight; tracks occupancy and guards against over/underflow.
module pheap_arb
  import pheapTypes::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DEPTH   = 15,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  opcode_t [NREQ-1:0]         op,
  input  logic [NREQ-1:0][31:0]      pri,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            resp_valid,
  output logic [31:0]                resp_pri,
  output logic                       resp_err,
  output logic                       pq_valid,
  output opcode_t                    pq_toperation,
  output logic [31:0]                pq_priorityIn,
  input  logic                       pq_rdy,
  input  logic                       pq_valid_out,
  input  logic [31:0]                pq_priorityOut,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t      state, state_nxt;
  logic [PW-1:0]   rr_ptr, win_idx, arb_idx;
  opcode_t         win_op;
  logic [31:0]     win_pri;
  logic [TW-1:0]   wdog;
  logic [NREQ-1:0] arb_grant;
  logic            arb_any, accept, reject, wdog_hit;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .any    (arb_any)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (arb_grant[PW'(i)]) arb_idx = PW'(i);
  end

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign accept   = (state == IDLE) && arb_any && pq_rdy;
  assign reject   = (op[arb_idx] == LEQ) ? full : empty;
  assign wdog_hit = (wdog == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = reject ? DONE : ISSUE;
      ISSUE:    state_nxt = (win_op == LEQ) ? DONE : DEQ_WAIT;
      DEQ_WAIT: if (pq_valid_out || wdog_hit) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are held at their reset values while rst is high so an abandoned
  // operation can never emit a stray grant, command or response.
  always_comb begin
    gnt           = '0;
    resp_valid    = '0;
    pq_valid      = 1'b0;
    pq_toperation = LEQ;
    pq_priorityIn = '0;
    if (!rst) begin
      if (accept) gnt = arb_grant;
      case (state)
        ISSUE: begin
          pq_valid      = 1'b1;
          pq_toperation = win_op;
          pq_priorityIn = (win_op == LEQ) ? win_pri : '0;
        end
        DONE:    resp_valid[win_idx] = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      win_idx  <= '0;
      win_op   <= LEQ;
      win_pri  <= '0;
      count    <= '0;
      wdog     <= '0;
      resp_pri <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          win_idx <= arb_idx;
          win_op  <= op[arb_idx];
          win_pri <= pri[arb_idx];
          if (reject) begin
            resp_pri <= '0;
            resp_err <= 1'b1;
          end
        end
        ISSUE: if (win_op == LEQ) begin
          if (!full) count <= count + 1'b1;
          resp_pri <= win_pri;
          resp_err <= 1'b0;
        end else begin
          if (!empty) count <= count - 1'b1;
          wdog <= '0;
        end
        DEQ_WAIT: if (pq_valid_out) begin
          resp_pri <= pq_priorityOut;
          resp_err <= 1'b0;
        end else if (wdog_hit) begin
          resp_pri <= '0;
          resp_err <= 1'b1;
        end else begin
          wdog <= wdog + 1'b1;
        end
        DONE: rr_ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pheap_arb.sv
// Bench for pheap_arb: a max-first pheap stand-in, a transaction-timeline
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_pheap_arb;
  import pheapTypes::*;

  localparam int NREQ    = 4;
  localparam int DEPTH   = 15;
  localparam int TIMEOUT = 64;

  typedef logic [1:0] idx_t;

  logic                  clk, rst;
  logic [NREQ-1:0]       req;
  opcode_t [NREQ-1:0]    op;
  logic [NREQ-1:0][31:0] pri;
  logic [NREQ-1:0]       gnt, resp_valid;
  logic [31:0]           resp_pri;
  logic                  resp_err;
  logic                  pq_valid;
  opcode_t               pq_toperation;
  logic [31:0]           pq_priorityIn;
  logic                  pq_rdy, pq_valid_out;
  logic [31:0]           pq_priorityOut;
  logic [3:0]            count;
  logic                  empty, full;

  pheap_arb #(.NREQ(NREQ), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .pri(pri), .gnt(gnt),
    .resp_valid(resp_valid), .resp_pri(resp_pri), .resp_err(resp_err),
    .pq_valid(pq_valid), .pq_toperation(pq_toperation), .pq_priorityIn(pq_priorityIn),
    .pq_rdy(pq_rdy), .pq_valid_out(pq_valid_out), .pq_priorityOut(pq_priorityOut),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        tie_low = 1'b0;
  logic [31:0] hq[$];
  logic [31:0] mlist[$];

  // observations of the DUT used by the directed checks
  logic [NREQ-1:0] gseen = '0;
  int          resp_seen = 0, gnt_cyc = 0, last_lat = 0, pqv_cnt = 0;
  logic [31:0] last_rpri = '0, last_pq_pri = '0;
  logic        last_rerr = 1'b0;
  int          gnt_log[$];
  logic [31:0] rpri_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pop();
    int bi = 0;
    for (int k = 1; k < mlist.size(); k++) if (mlist[k] > mlist[bi]) bi = k;
    model_pop = mlist[bi];
    mlist.delete(bi);
  endfunction

  function automatic logic [31:0] heap_pop();
    int bi = 0;
    for (int k = 1; k < hq.size(); k++) if (hq[k] > hq[bi]) bi = k;
    heap_pop = hq[bi];
    hq.delete(bi);
  endfunction

  // pheap stand-in: returns the largest stored priority one cycle after a DEQ
  initial begin
    logic sv, sr;
    opcode_t so;
    logic [31:0] sp;
    pq_valid_out = 1'b0;
    pq_priorityOut = '0;
    forever begin
      @(negedge clk);
      sv = pq_valid; so = pq_toperation; sp = pq_priorityIn; sr = rst;
      @(posedge clk);
      #1;
      pq_valid_out = 1'b0;
      if (sr) hq.delete();
      else if (sv && so == LEQ) hq.push_back(sp);
      else if (sv && hq.size() > 0) begin
        pq_priorityOut = heap_pop();
        pq_valid_out = !tie_low;
      end
    end
  end

  // Reference model: each accepted request schedules its issue, count-change
  // and response cycles; the DUT is compared against that timeline every cycle.
  initial begin
    int cyc, t_issue, t_resp, t_cnt, cdelta, m_count, rrp, gidx;
    idx_t c, w, e_w;
    logic found;
    opcode_t e_op;
    logic [31:0] e_ipri, e_pri;
    logic e_err;
    logic [NREQ-1:0] eg, erv;
    cyc = 0; t_issue = -1; t_resp = -1; t_cnt = -1; cdelta = 0; m_count = 0; rrp = 0;
    e_w = '0; e_op = LEQ; e_ipri = '0; e_pri = '0; e_err = 1'b0; w = '0;
    forever begin
      @(negedge clk);
      cyc++;
      gseen = gnt;
      if (|gnt) begin
        gidx = 0;
        for (int k = 0; k < NREQ; k++) if (gnt[idx_t'(k)]) gidx = k;
        gnt_log.push_back(gidx);
        gnt_cyc = cyc;
      end
      if (|resp_valid) begin
        resp_seen++;
        last_rpri = resp_pri;
        last_rerr = resp_err;
        last_lat = cyc - gnt_cyc;
        rpri_log.push_back(resp_pri);
      end
      if (pq_valid) begin
        pqv_cnt++;
        last_pq_pri = pq_priorityIn;
      end
      if (rst) begin
        t_issue = -1; t_resp = -1; t_cnt = -1; m_count = 0; rrp = 0;
        mlist.delete();
      end else begin
        if (cyc == t_cnt) m_count += cdelta;
        eg = '0;
        if (t_resp < cyc && pq_rdy && |req) begin
          found = 1'b0;
          for (int k = 0; k < NREQ; k++) begin
            c = idx_t'((rrp + k) % NREQ);
            if (!found && req[c]) begin found = 1'b1; w = c; end
          end
          eg[w] = 1'b1;
          rrp = (int'(w) + 1) % NREQ;
          e_w = w;
          e_op = op[w];
          if ((op[w] == LEQ && m_count == DEPTH) || (op[w] == DEQ && m_count == 0)) begin
            t_issue = -1; t_cnt = -1; t_resp = cyc + 1; e_pri = '0; e_err = 1'b1;
          end else if (op[w] == LEQ) begin
            t_issue = cyc + 1; t_cnt = cyc + 2; cdelta = 1; t_resp = cyc + 2;
            e_ipri = pri[w]; e_pri = pri[w]; e_err = 1'b0;
            mlist.push_back(pri[w]);
          end else begin
            t_issue = cyc + 1; t_cnt = cyc + 2; cdelta = -1; e_ipri = '0;
            e_pri = model_pop(); e_err = 1'b0; t_resp = cyc + 3;
            if (tie_low) begin
              e_pri = '0; e_err = 1'b1; t_resp = cyc + 2 + TIMEOUT;
            end
          end
        end
        erv = '0;
        if (cyc == t_resp) erv[e_w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("resp_valid", 32'(resp_valid), 32'(erv));
        chk("pq_valid", 32'(pq_valid), 32'(cyc == t_issue));
        if (cyc == t_issue) begin
          chk("pq_toperation", 32'(pq_toperation), 32'(e_op));
          chk("pq_priorityIn", pq_priorityIn, e_ipri);
        end
        if (cyc == t_resp) begin
          chk("resp_pri", resp_pri, e_pri);
          chk("resp_err", 32'(resp_err), 32'(e_err));
        end
        chk("count", 32'(count), m_count);
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("full", 32'(full), 32'(m_count == DEPTH));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~gseen;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic ask(input idx_t i, input opcode_t o, input logic [31:0] p);
    req[i] = 1'b1;
    op[i]  = o;
    pri[i] = p;
  endtask

  task automatic wait_resps(input int target);
    int k = 0;
    while (resp_seen < target && k < 200) begin
      step();
      k++;
    end
    chk("resp_wait", resp_seen, target);
  endtask

  task automatic chk_idle();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_pri", resp_pri, 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_pq_valid", 32'(pq_valid), 0);
    chk("rst_pq_toperation", 32'(pq_toperation), 32'(LEQ));
    chk("rst_pq_priorityIn", pq_priorityIn, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    steps(2);
    rst = 1'b0;
    chk_idle();
  endtask

  initial begin
    int base;
    rst = 1'b1;
    req = '0;
    pq_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op[idx_t'(i)] = LEQ;
      pri[idx_t'(i)] = '0;
    end

    // single enqueue
    do_reset();
    pqv_cnt = 0;
    base = resp_seen;
    ask(2'd0, LEQ, 32'h38);
    wait_resps(base + 1);
    chk("leq_pri", last_rpri, 32'h38);
    chk("leq_err", 32'(last_rerr), 0);
    chk("leq_lat", last_lat, 2);
    chk("leq_pq_pri", last_pq_pri, 32'h38);
    chk("leq_pqv", pqv_cnt, 1);
    chk("leq_count", 32'(count), 1);

    // four simultaneous enqueues, held off by pq_rdy=0 first
    do_reset();
    gnt_log.delete();
    pq_rdy = 1'b0;
    ask(2'd0, LEQ, 32'h10);
    ask(2'd1, LEQ, 32'h90);
    ask(2'd2, LEQ, 32'h85);
    ask(2'd3, LEQ, 32'h84);
    steps(3);
    chk("stall_gnts", gnt_log.size(), 0);
    pq_rdy = 1'b1;
    base = resp_seen;
    wait_resps(base + 4);
    chk("rr_size", gnt_log.size(), 4);
    for (int k = 0; k < 4; k++) chk("rr_order", gnt_log[k], k);
    chk("four_count", 32'(count), 4);

    // drain in pheap order; DEQ priority input is don't-care
    rpri_log.delete();
    for (int k = 0; k < 4; k++) begin
      base = resp_seen;
      ask(2'd2, DEQ, 32'hDEAD);
      wait_resps(base + 1);
    end
    chk("deq_size", rpri_log.size(), 4);
    chk("deq0", rpri_log[0], 32'h90);
    chk("deq1", rpri_log[1], 32'h85);
    chk("deq2", rpri_log[2], 32'h84);
    chk("deq3", rpri_log[3], 32'h10);
    chk("deq_err", 32'(last_rerr), 0);
    chk("deq_lat", last_lat, 3);
    chk("deq_count", 32'(count), 0);
    chk("deq_empty", 32'(empty), 1);

    // dequeue while empty is rejected without touching the pheap
    pqv_cnt = 0;
    base = resp_seen;
    ask(2'd1, DEQ, 32'h1234);
    wait_resps(base + 1);
    chk("underflow_err", 32'(last_rerr), 1);
    chk("underflow_pri", last_rpri, 0);
    chk("underflow_lat", last_lat, 1);
    chk("underflow_pqv", pqv_cnt, 0);
    chk("underflow_count", 32'(count), 0);

    // rr pointer now 2: requesters 1 and 3 together -> 3 first, then 1
    gnt_log.delete();
    base = resp_seen;
    ask(2'd1, LEQ, 32'h11);
    ask(2'd3, LEQ, 32'h33);
    wait_resps(base + 2);
    chk("wrap_size", gnt_log.size(), 2);
    chk("wrap_first", gnt_log[0], 3);
    chk("wrap_second", gnt_log[1], 1);
    chk("wrap_count", 32'(count), 2);

    // fill past capacity
    do_reset();
    pqv_cnt = 0;
    for (int k = 0; k <= DEPTH; k++) begin
      base = resp_seen;
      ask(2'd0, LEQ, 32'(k * 3 + 1));
      wait_resps(base + 1);
    end
    chk("overflow_err", 32'(last_rerr), 1);
    chk("overflow_pri", last_rpri, 0);
    chk("overflow_lat", last_lat, 1);
    chk("overflow_full", 32'(full), 1);
    chk("overflow_count", 32'(count), DEPTH);
    chk("overflow_pqv", pqv_cnt, DEPTH);

    // dequeue watchdog, then reset while waiting on the pheap
    do_reset();
    base = resp_seen;
    ask(2'd0, LEQ, 32'h55);
    wait_resps(base + 1);
    tie_low = 1'b1;
    base = resp_seen;
    ask(2'd0, DEQ, 32'h0);
    wait_resps(base + 1);
    chk("timeout_err", 32'(last_rerr), 1);
    chk("timeout_pri", last_rpri, 0);
    chk("timeout_lat", last_lat, TIMEOUT + 2);
    chk("timeout_count", 32'(count), 0);
    base = resp_seen;
    ask(2'd0, LEQ, 32'h66);
    wait_resps(base + 1);
    ask(2'd0, LEQ, 32'h77);
    wait_resps(base + 2);
    ask(2'd0, DEQ, 32'h0);
    steps(10);
    chk("midwait_count", 32'(count), 1);
    base = resp_seen;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle();
    steps(5);
    chk("abandoned_resp", resp_seen, base);
    tie_low = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL sim_time_limit: got time %0t expected completion", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pheap_arb.md
PHEAP_ARB -- requirements
Module: pheap_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; DEPTH, default 15, heap capacity in entries; TIMEOUT, default 64, maximum cycles to wait for a dequeue result.
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req  in  NREQ  per-requester request; SHALL be held until the matching gnt.
REQ-005 op  in  NREQ x opcode_t  per-requester operation: LEQ (enqueue) or DEQ (dequeue); SHALL be stable while req is high.
REQ-006 pri  in  NREQ x 32  per-requester enqueue priority; ignored for DEQ.
REQ-007 gnt  out  NREQ  one-hot, one-cycle pulse marking the accepted request.
REQ-008 resp_valid  out  NREQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-009 resp_pri  out  32  completion data, qualified by resp_valid.
REQ-010 resp_err  out  1  error flag, qualified by resp_valid.
REQ-011 pq_valid, pq_toperation, pq_priorityIn  out  1 / opcode_t / 32  command to the pheap.
REQ-012 pq_rdy, pq_valid_out, pq_priorityOut  in  1 / 1 / 32  pheap ready, dequeue-result strobe and dequeue-result data.
REQ-013 count  out  $clog2(DEPTH+1)  heap occupancy.
REQ-014 empty, full  out  1 each  count==0 and count==DEPTH respectively.

Function
REQ-015 The FSM SHALL have four states, IDLE, ISSUE, DEQ_WAIT and DONE, with exactly one operation outstanding at a time.
REQ-016 IDLE: when any req is high and pq_rdy==1, the block SHALL select a winner round-robin, starting the search at rr_ptr.
REQ-017 In that same cycle it SHALL pulse gnt[winner] and register winner, op and pri.
REQ-018 IDLE with an LEQ winner while full, or a DEQ winner while empty, SHALL NOT issue to the pheap; the block SHALL go to DONE with resp_err=1 and resp_pri=0.
REQ-019 IDLE otherwise SHALL go to ISSUE.
REQ-020 ISSUE SHALL assert pq_valid for exactly one cycle with the registered op and pri; pq_priorityIn SHALL be 0 for DEQ.
REQ-021 In ISSUE, an LEQ SHALL increment count and go to DONE with resp_pri equal to the enqueued pri.
REQ-022 In ISSUE, a DEQ SHALL decrement count, clear the watchdog and go to DEQ_WAIT.
REQ-023 DEQ_WAIT: on pq_valid_out==1 the block SHALL capture pq_priorityOut and go to DONE with resp_err=0.
REQ-024 DEQ_WAIT: on the TIMEOUT-th cycle without pq_valid_out it SHALL go to DONE with resp_err=1 and resp_pri=0; count SHALL remain decremented.
REQ-025 pq_valid_out outside DEQ_WAIT SHALL be ignored.
REQ-026 DONE SHALL pulse resp_valid[winner] for one cycle, set rr_ptr=(winner+1) mod NREQ and return to IDLE.
REQ-027 Request-to-gnt latency SHALL be 0 cycles when in IDLE with pq_rdy high.
REQ-028 LEQ gnt-to-resp_valid latency SHALL be 2 cycles.
REQ-029 A rejected request's gnt-to-resp_valid latency SHALL be 1 cycle.
REQ-030 DEQ gnt-to-resp_valid latency SHALL be 2 cycles plus the pheap latency.
REQ-031 While pq_rdy==0 in IDLE, no gnt SHALL be issued and requests SHALL wait; no request SHALL be dropped.
REQ-032 A requester SHALL be served again no sooner than after every other pending requester has been served once (no starvation).
REQ-033 count SHALL never wrap past 0 or DEPTH.
REQ-034 gnt, resp_valid and pq_valid SHALL be mutually exclusive in time.

Reset
REQ-035 On rst: state=IDLE, rr_ptr=0, count=0, watchdog=0.
REQ-036 On rst: gnt=0, resp_valid=0, resp_pri=0, resp_err=0, pq_valid=0, pq_toperation=LEQ, pq_priorityIn=0.
REQ-037 On rst: empty=1, full=0.
REQ-038 rst asserted mid-operation SHALL abandon the in-flight operation with no response; the pheap SHALL be reset concurrently by the same rst.

Structure
REQ-039 opcode_t SHALL remain in pheapTypes; the arbiter state enum SHALL be added to pheapTypes.
REQ-040 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and rr_ptr; outputs one-hot grant and any).

Verification
REQ-041 Reset, then requester 0 issues LEQ 0x38 -> gnt[0]; one pq_valid with LEQ/0x38; resp_valid[0] with resp_pri=0x38, err=0; count=1.
REQ-042 Requesters 0..3 issue LEQ 0x10, 0x90, 0x85, 0x84 simultaneously -> grants in order 0,1,2,3; count=4.
REQ-043 Requester 2 then issues four DEQs -> resp_pri in pheap order, err=0; count=0; empty=1.
REQ-044 DEQ while empty -> resp_err=1 one cycle after gnt; no pq_valid issued.
REQ-045 DEPTH+1 LEQs -> the last has resp_err=1 and full=1; pq_valid count equals DEPTH.
REQ-046 DEQ with pq_valid_out tied low -> resp_err=1 after TIMEOUT cycles; then rst mid-DEQ_WAIT -> all outputs return to reset values next cycle.
